// File: rtl/rst_seq_ctrl.sv
// Power-on reset sequencer: pulses the PLL reset, waits for a filtered lock, holds
// sys_rst_n low for a fixed time, and turns a debounced button press into a soft reset.
module rst_seq_ctrl #(
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int HOLD_CYC     = 256,
  parameter int DEB_CYC      = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       btn_n,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [1:0] state,
  output logic [3:0] retry_cnt
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > PLL_RST_CYC)
                         ? ((LOCK_TIMEOUT > HOLD_CYC) ? LOCK_TIMEOUT : HOLD_CYC)
                         : ((PLL_RST_CYC > HOLD_CYC) ? PLL_RST_CYC : HOLD_CYC);
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int DEB_W  = $clog2(DEB_CYC + 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  logic [1:0]       lock_sync_q, btn_sync_q;
  logic             lock_s, btn_s;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             btn_db_q, btn_db_d;
  logic             press_q, press_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_rst_q, sys_rst_n_q;

  assign lock_s = lock_sync_q[1];
  assign btn_s  = btn_sync_q[1];

  // Synchronizers reset to the idle level of each input (unlocked, released).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_q <= 2'b00;
      btn_sync_q  <= 2'b11;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_lock};
      btn_sync_q  <= {btn_sync_q[0], btn_n};
    end
  end

  always_comb begin
    deb_d    = deb_q;
    btn_db_d = btn_db_q;
    if (btn_s == btn_db_q) begin
      deb_d = '0;
    end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
      btn_db_d = btn_s;
      deb_d    = '0;
    end else begin
      deb_d = deb_q + 1'b1;
    end
    press_d = btn_db_q & ~btn_db_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q    <= '0;
      btn_db_q <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      deb_q    <= deb_d;
      btn_db_q <= btn_db_d;
      press_q  <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    stab_d  = '0;
    retry_d = retry_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYC - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        // A stable lock on the timeout cycle still counts as a success.
        if (lock_s && stab_q == STAB_W'(LOCK_STABLE - 1)) begin
          state_d = S_HOLD;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = S_PLL_RST;
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (!lock_s)                            state_d = S_PLL_RST;
        else if (cnt_q == CNT_W'(HOLD_CYC - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = S_PLL_RST;
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        end else if (press_q) begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    if (state_d != state_q) begin
      cnt_d  = '0;
      stab_d = '0;
    end
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      stab_q      <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == S_PLL_RST);
      sys_rst_n_q <= (state_d == S_RUN);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule
